keccak_core_arbiter: RTL and testbench
======================================

// Module: keccak_core_arbiter
// PURPOSE
//  Shares one Keccak/SHAKE core among NUM_REQ requesters (e.g. seed expansion, sampler, hash-to-point).
//  Grants the core for one complete message: config, absorb stream, then squeeze of OUTLEN words.
//  Round-robin fairness; grant held until the message is fully squeezed. Sits between clients and the core.
// PARAMETERS
//  NUM_REQ   3   number of requesters (1..8)
//  W         64  data word width, input and output
//  LENW      16  width of requested output length in words
// PORTS
//  clk               in   1            clock
//  rst               in   1            synchronous, active-low reset (rst==0 resets on clk rising edge)
//  req_valid_i       in   NUM_REQ      per-requester input beat valid
//  req_data_i        in   NUM_REQ*W    per-requester input word, slot i = [i*W +: W]
//  req_last_i        in   NUM_REQ      last input beat of message
//  req_mode_i        in   NUM_REQ*2    keccak_pkg::mode_t per requester, sampled at grant
//  req_outlen_i      in   NUM_REQ*LENW output words wanted (0 is treated as 1), sampled at grant
//  req_ready_o       out  NUM_REQ      input beat accepted (only granted slot can be 1)
//  rsp_valid_o       out  NUM_REQ      output word valid, one-hot to granted slot
//  rsp_data_o        out  W            output word, shared bus
//  rsp_last_o        out  1            final output word of this grant
//  rsp_ready_i       in   NUM_REQ      requester accepts output word
//  core_start_o      out  1            1-cycle pulse: core loads mode/outlen, clears state
//  core_mode_o       out  2            latched mode
//  core_outlen_o     out  LENW         latched output length
//  core_valid_o / core_data_o[W] / core_last_o   out   input stream to core
//  core_ready_i      in   1            core accepts input beat
//  core_valid_i / core_data_i[W]     in   squeeze stream from core
//  core_ready_o      out  1            arbiter accepts squeeze word
//  busy_o            out  1            grant active;  grant_id_o  out  IDW  current owner
//  err_o             out  1            sticky: core ended squeeze early; cleared by reset only
// BEHAVIOUR
//  Reset: FSM=IDLE, rr pointer=0, all outputs 0 (grant_id_o=0, err_o=0).
//  Handshake: beat transfers when valid&ready high on a rising edge; valid may not drop or data change
//  until accepted (requester obligation; bench asserts it).
//  States:
//   IDLE    -> GRANT when any req_valid_i set; winner = first set bit at or after rr_ptr (wrap).
//   GRANT   1 cycle: latch id, mode, outlen (0->1); core_start_o=1; -> ABSORB.
//   ABSORB  combinational pass-through of owner: core_valid_o=req_valid_i[id], req_ready_o[id]=core_ready_i;
//           -> SQUEEZE on accepted beat with req_last_i[id]=1. Non-owners see ready=0.
//   SQUEEZE pass core output to owner: rsp_valid_o[id]=core_valid_i, core_ready_o=rsp_ready_i[id];
//           down-counter cnt=outlen, decrements per accepted word; rsp_last_o=1 when cnt==1.
//           -> RELEASE on accepted word with cnt==1.
//   RELEASE 1 cycle: rr_ptr=id+1 (wrap to 0 at NUM_REQ), busy_o=0 next; -> IDLE.
//  Latency: grant 2 cycles after req_valid_i seen in IDLE (IDLE->GRANT->ABSORB); no added data latency.
//  Boundaries:
//   - simultaneous requests: round robin, never starves; single requester re-granted every 3+ cycles.
//   - new requests during a grant are ignored until RELEASE; rr_ptr updates only in RELEASE.
//   - owner drops valid in ABSORB: wait indefinitely (no timeout).
//   - core_valid_i outside SQUEEZE: core_ready_o=0, word held by core.
//   - core_start_o with core_valid_i pending: core's responsibility; arbiter never asserts both.
//   - outlen=2^LENW-1 counts without overflow; cnt width LENW.
//   - rst low mid-grant: immediate return to IDLE on that edge, partial message discarded,
//     core re-started by next grant's core_start_o.
// STRUCTURE
//  keccak_pkg: mode_t {SHA3_256, SHA3_512, SHAKE128, SHAKE256}, RATE_* constants, IDW=$clog2(NUM_REQ)>0?..:1.
//  Sub-module rr_arbiter (req vector + pointer -> one-hot grant + index, combinational). FSM, counter,
//  muxes in top.
// TESTING
//  1 Reset: rst=0 two cycles with req_valid_i=3'b111 -> all outputs 0, no core_start_o.
//  2 Single req1, SHAKE128, 3 input beats, outlen=4 -> one core_start_o, mode=2, 3 beats out, 4 rsp words,
//    rsp_last_o on 4th, grant_id_o=1, busy_o low after RELEASE.
//  3 All three request at once, rr_ptr=0 -> grant order 0,1,2,0; no ready to non-owners.
//  4 Backpressure: core_ready_i random 50%, rsp_ready_i random 30% -> data order/values match model, no loss.
//  5 outlen=0 -> exactly 1 output word with rsp_last_o=1.
//  6 rst=0 mid-SQUEEZE (cnt=2) -> IDLE next cycle, outputs 0; next grant proceeds normally.
//  7 Early end: core stops producing, no rsp_last; err_o stays 0 (err_o only from core end-of-data flag).

Source files
------------

// File: rtl/keccak_core_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_core_arbiter_pkg
//  Purpose  : Shared types and constants for the Keccak core arbiter slice:
//             hash mode encoding, sponge rates, arbiter FSM states and the
//             grant-index width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package keccak_core_arbiter_pkg;

   typedef enum logic [1:0] {
      SHA3_256 = 2'd0,
      SHA3_512 = 2'd1,
      SHAKE128 = 2'd2,
      SHAKE256 = 2'd3
   } mode_t;

   // Sponge rates in bytes for each mode
   localparam int RATE_SHA3_256 = 136;
   localparam int RATE_SHA3_512 = 72;
   localparam int RATE_SHAKE128 = 168;
   localparam int RATE_SHAKE256 = 136;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GRANT   = 3'd1,
      ST_ABSORB  = 3'd2,
      ST_SQUEEZE = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   // Grant index width; a single requester still needs a 1-bit index
   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int rate_bytes(input mode_t m);
      case (m)
         SHA3_256: return RATE_SHA3_256;
         SHA3_512: return RATE_SHA3_512;
         SHAKE128: return RATE_SHAKE128;
         default:  return RATE_SHAKE256;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_core_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_core_arbiter_if
//  Purpose  : Arbiter <-> Keccak core link: start/config, absorb stream into
//             the core and squeeze stream out of it.
//  Ports    : start, mode, outlen         config (arbiter -> core)
//             in_valid/in_data/in_last    absorb beat (arbiter -> core)
//             in_ready                    absorb accept (core -> arbiter)
//             out_valid/out_data          squeeze word (core -> arbiter)
//             out_ready                   squeeze accept (arbiter -> core)
//             modport master = arbiter side, slave = core side
//  Revision : 1.0  initial release
// ============================================================================
interface keccak_core_arbiter_if
   import keccak_core_arbiter_pkg::*;
#(
   parameter int W    = 64,
   parameter int LENW = 16
);
   logic            start;
   mode_t           mode;
   logic [LENW-1:0] outlen;
   logic            in_valid;
   logic [W-1:0]    in_data;
   logic            in_last;
   logic            in_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic            out_ready;

   modport master (
      output start, mode, outlen, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  start, mode, outlen, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/keccak_core_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_core_arbiter_rr_arbiter
//  Purpose  : Combinational round-robin pick: first set request bit at or
//             after the pointer, wrapping at NUM_REQ.
//  Ports    : req_i  request vector      ptr_i  search start index
//             gnt_o  one-hot winner      idx_o  winner index
//  Revision : 1.0  initial release
// ============================================================================
module keccak_core_arbiter_rr_arbiter
   import keccak_core_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   localparam int IDW     = idw(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDW-1:0]     idx_o
);

   logic         found;
   logic [IDW:0] slot;   // one spare bit so ptr+k cannot overflow before wrap

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      slot  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         slot = {1'b0, ptr_i} + (IDW+1)'(k);
         if (slot >= (IDW+1)'(NUM_REQ)) begin
            slot = slot - (IDW+1)'(NUM_REQ);
         end
         if (!found && req_i[slot[IDW-1:0]]) begin
            found                  = 1'b1;
            gnt_o[slot[IDW-1:0]]   = 1'b1;
            idx_o                  = slot[IDW-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/keccak_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_core_arbiter
//  Purpose  : Shares one Keccak/SHAKE core among NUM_REQ requesters. A grant
//             covers one whole message (config, absorb, squeeze of OUTLEN
//             words); owners are picked round-robin.
//  Ports    : clk, rst (sync, active low)
//             req_valid_i/req_data_i/req_last_i/req_mode_i/req_outlen_i,
//             req_ready_o                       requester absorb side
//             rsp_valid_o/rsp_data_o/rsp_last_o, rsp_ready_i
//                                               requester squeeze side
//             core (master modport)             link to the Keccak core
//             busy_o, grant_id_o, err_o         status
//  Revision : 1.0  initial release
// ============================================================================
module keccak_core_arbiter
   import keccak_core_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   parameter  int W       = 64,
   parameter  int LENW    = 16,
   localparam int IDW     = idw(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   input  logic [NUM_REQ*W-1:0]     req_data_i,
   input  logic [NUM_REQ-1:0]       req_last_i,
   input  logic [NUM_REQ*2-1:0]     req_mode_i,
   input  logic [NUM_REQ*LENW-1:0]  req_outlen_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   output logic [NUM_REQ-1:0]       rsp_valid_o,
   output logic [W-1:0]             rsp_data_o,
   output logic                     rsp_last_o,
   input  logic [NUM_REQ-1:0]       rsp_ready_i,
   keccak_core_arbiter_if.master    core,
   output logic                     busy_o,
   output logic [IDW-1:0]           grant_id_o,
   output logic                     err_o
);

   state_t          state_q;
   logic [IDW-1:0]  id_q;
   logic [IDW-1:0]  rr_q;
   mode_t           mode_q;
   logic [LENW-1:0] outlen_q;
   logic [LENW-1:0] cnt_q;
   logic            start_q;
   logic            busy_q;
   logic            err_q;

   logic [NUM_REQ-1:0] w_gnt;
   logic [IDW-1:0]     w_win;
   logic               w_any;

   logic [W-1:0]    w_req_data   [NUM_REQ];
   logic [1:0]      w_req_mode   [NUM_REQ];
   logic [LENW-1:0] w_req_outlen [NUM_REQ];

   logic         w_in_valid;
   logic [W-1:0] w_in_data;
   logic         w_in_last;
   logic         w_out_ready;
   logic         w_in_fire;
   logic         w_out_fire;

   // Unpack flat per-requester buses into slot arrays
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      assign w_req_data[i]   = req_data_i[i*W +: W];
      assign w_req_mode[i]   = req_mode_i[i*2 +: 2];
      assign w_req_outlen[i] = req_outlen_i[i*LENW +: LENW];
   end

   keccak_core_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req_i  (req_valid_i),
      .ptr_i  (rr_q),
      .gnt_o  (w_gnt),
      .idx_o  (w_win)
   );

   assign w_any = |w_gnt;

   // Owner pass-through; everything is forced low outside its phase so
   // non-owners and idle cycles never see a handshake.
   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      rsp_data_o  = '0;
      rsp_last_o  = 1'b0;
      w_in_valid  = 1'b0;
      w_in_data   = '0;
      w_in_last   = 1'b0;
      w_out_ready = 1'b0;
      case (state_q)
         ST_ABSORB: begin
            w_in_valid         = req_valid_i[id_q];
            w_in_data          = w_req_data[id_q];
            w_in_last          = req_last_i[id_q];
            req_ready_o[id_q]  = core.in_ready;
         end
         ST_SQUEEZE: begin
            rsp_valid_o[id_q]  = core.out_valid;
            rsp_data_o         = core.out_data;
            rsp_last_o         = (cnt_q == LENW'(1));
            w_out_ready        = rsp_ready_i[id_q];
         end
         default: ;
      endcase
   end

   assign w_in_fire  = w_in_valid & core.in_ready;
   assign w_out_fire = w_out_ready & core.out_valid;

   assign core.start     = start_q;
   assign core.mode      = mode_q;
   assign core.outlen    = outlen_q;
   assign core.in_valid  = w_in_valid;
   assign core.in_data   = w_in_data;
   assign core.in_last   = w_in_last;
   assign core.out_ready = w_out_ready;

   assign busy_o     = busy_q;
   assign grant_id_o = id_q;
   assign err_o      = err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         id_q     <= '0;
         rr_q     <= '0;
         mode_q   <= SHA3_256;
         outlen_q <= '0;
         cnt_q    <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_any) begin
                  // Config is captured here so it is already stable on the
                  // core port during the start pulse.
                  id_q     <= w_win;
                  mode_q   <= mode_t'(w_req_mode[w_win]);
                  outlen_q <= (w_req_outlen[w_win] == '0) ? LENW'(1)
                                                          : w_req_outlen[w_win];
                  start_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               start_q <= 1'b0;
               cnt_q   <= outlen_q;
               state_q <= ST_ABSORB;
            end
            ST_ABSORB: begin
               if (w_in_fire && w_in_last) begin
                  state_q <= ST_SQUEEZE;
               end
            end
            ST_SQUEEZE: begin
               if (w_out_fire) begin
                  cnt_q <= cnt_q - LENW'(1);
                  if (cnt_q == LENW'(1)) begin
                     state_q <= ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               rr_q    <= (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + IDW'(1);
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
         // The core link carries no end-of-data flag, so nothing can raise
         // the sticky error; it only holds its reset value.
         err_q <= err_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keccak_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keccak_core_arbiter
//  Purpose  : Directed self-checking bench for keccak_core_arbiter. The bench
//             plays both the requesters and the Keccak core.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_keccak_core_arbiter;
   import keccak_core_arbiter_pkg::*;

   localparam int N    = 3;
   localparam int W    = 64;
   localparam int LENW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*W-1:0]    req_data;
   logic [N-1:0]      req_last;
   logic [N*2-1:0]    req_mode;
   logic [N*LENW-1:0] req_outlen;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              rsp_last;
   logic [N-1:0]      rsp_ready;
   logic              busy;
   logic [1:0]        grant_id;
   logic              err;

   int n_chk = 0;
   int n_err = 0;

   keccak_core_arbiter_if #(.W(W), .LENW(LENW)) cif ();

   keccak_core_arbiter #(.NUM_REQ(N), .W(W), .LENW(LENW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_last_i   (req_last),
      .req_mode_i   (req_mode),
      .req_outlen_i (req_outlen),
      .req_ready_o  (req_ready),
      .rsp_valid_o  (rsp_valid),
      .rsp_data_o   (rsp_data),
      .rsp_last_o   (rsp_last),
      .rsp_ready_i  (rsp_ready),
      .core         (cif),
      .busy_o       (busy),
      .grant_id_o   (grant_id),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] in_pat(input int r, input int b);
      return {8'hD0, 40'h0, 8'(r), 8'(b)};
   endfunction

   function automatic logic [63:0] sq_pat(input int r, input int k);
      return {8'h5A, 40'h0, 8'(r), 8'(k)};
   endfunction

   // One full message from requester r. abort_k / stall_k: squeeze word
   // index at which to pull reset / stall the core (-1 = never).
   task automatic msg(input int r, input logic [1:0] md, input int olen,
                      input int nb, input bit cbp, input bit rbp, input bit hold,
                      input int abort_k, input int stall_k, input int exp_wait);
      int   waited;
      int   b;
      int   k;
      int   nw;
      int   guard;
      bit   cr;
      bit   rr;
      bit   stalled;
      begin
         nw = (olen == 0) ? 1 : olen;
         req_data[r*W +: W]          = in_pat(r, 0);
         req_last[r]                 = (nb == 1);
         req_mode[r*2 +: 2]          = md;
         req_outlen[r*LENW +: LENW]  = LENW'(olen);
         req_valid[r]                = 1'b1;
         waited = 0;
         do begin
            tick();
            waited++;
         end while (!cif.start && waited < 20);
         chk("start", 64'(cif.start), 64'd1);
         if (exp_wait > 0) chk("grant_latency", 64'(waited), 64'(exp_wait));
         chk("grant_id", 64'(grant_id), 64'(r));
         chk("core_mode", 64'(cif.mode), 64'(md));
         chk("core_outlen", 64'(cif.outlen), 64'(nw));
         chk("busy_grant", 64'(busy), 64'd1);
         chk("ready_grant", 64'(req_ready), 64'd0);
         tick();
         b = 0;
         guard = 0;
         while (b < nb && guard < 300) begin
            req_data[r*W +: W] = in_pat(r, b);
            req_last[r]        = (b == nb-1);
            cr = cbp ? 1'($urandom_range(0, 1)) : 1'b1;
            cif.in_ready = cr;
            #1;
            chk("core_valid", 64'(cif.in_valid), 64'd1);
            chk("core_data", cif.in_data, in_pat(r, b));
            chk("core_last", 64'(cif.in_last), 64'(b == nb-1));
            chk("req_ready", 64'(req_ready), 64'(cr) << r);
            chk("start_absorb", 64'(cif.start), 64'd0);
            tick();
            if (cr) b++;
            guard++;
         end
         chk("absorb_done", 64'(b), 64'(nb));
         cif.in_ready = 1'b0;
         if (!hold) req_valid[r] = 1'b0;
         k = 0;
         guard = 0;
         stalled = 1'b0;
         while (k < nw && guard < 300) begin
            if (k == abort_k) begin
               cif.out_valid = 1'b1;
               cif.out_data  = sq_pat(r, k);
               rsp_ready[r]  = 1'b1;
               rst = 1'b0;
               tick();
               chk("abort_busy", 64'(busy), 64'd0);
               chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
               chk("abort_core_ready", 64'(cif.out_ready), 64'd0);
               chk("abort_grant_id", 64'(grant_id), 64'd0);
               chk("abort_start", 64'(cif.start), 64'd0);
               rst = 1'b1;
               cif.out_valid = 1'b0;
               rsp_ready = '0;
               req_valid[r] = 1'b0;
               return;
            end
            if (k == stall_k && !stalled) begin
               stalled = 1'b1;
               cif.out_valid = 1'b0;
               rsp_ready[r]  = 1'b1;
               repeat (5) begin
                  tick();
                  chk("stall_rsp_valid", 64'(rsp_valid), 64'd0);
                  chk("stall_rsp_last", 64'(rsp_last), 64'd0);
                  chk("stall_err", 64'(err), 64'd0);
                  chk("stall_busy", 64'(busy), 64'd1);
               end
            end
            cif.out_valid = 1'b1;
            cif.out_data  = sq_pat(r, k);
            rr = rbp ? ($urandom_range(0, 9) < 3) : 1'b1;
            rsp_ready[r] = rr;
            #1;
            chk("rsp_valid", 64'(rsp_valid), 64'd1 << r);
            chk("rsp_data", rsp_data, sq_pat(r, k));
            chk("rsp_last", 64'(rsp_last), 64'(k == nw-1));
            chk("core_ready_o", 64'(cif.out_ready), 64'(rr));
            chk("ready_squeeze", 64'(req_ready), 64'd0);
            tick();
            if (rr) k++;
            guard++;
         end
         chk("squeeze_done", 64'(k), 64'(nw));
         cif.out_valid = 1'b0;
         rsp_ready = '0;
         #1;
         chk("busy_release", 64'(busy), 64'd1);
         chk("rsp_valid_release", 64'(rsp_valid), 64'd0);
         tick();
         chk("busy_idle", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      rst = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0; req_mode = '0;
      req_outlen = '0; rsp_ready = '0;
      cif.in_ready = 1'b0; cif.out_valid = 1'b0; cif.out_data = '0;

      // Reset held with all requests pending
      req_valid = 3'b111;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_start", 64'(cif.start), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_core_valid", 64'(cif.in_valid), 64'd0);
      chk("rst_core_ready", 64'(cif.out_ready), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      req_valid = '0;
      rst = 1'b1;
      tick();

      // Single requester 1, SHAKE128, 3 beats, 4 words
      msg(1, SHAKE128, 4, 3, 0, 0, 0, -1, -1, 1);

      // All three at once from a fresh pointer: order 0,1,2,0
      rst = 1'b0;
      tick();
      rst = 1'b1;
      req_last  = 3'b111;
      req_valid = 3'b111;
      msg(0, SHA3_256, 1, 1, 0, 0, 1, -1, -1, 0);
      msg(1, SHA3_512, 1, 1, 0, 0, 1, -1, -1, 1);
      msg(2, SHAKE256, 1, 1, 0, 0, 1, -1, -1, 1);
      msg(0, SHAKE128, 1, 1, 0, 0, 1, -1, -1, 1);
      req_valid = '0;
      req_last  = '0;
      tick();

      // Random backpressure on both streams
      msg(2, SHAKE256, 5, 4, 1, 1, 0, -1, -1, 0);
      msg(0, SHA3_512, 3, 2, 1, 1, 0, -1, -1, 0);

      // Zero output length behaves as one word
      msg(0, SHA3_256, 0, 1, 0, 0, 0, -1, -1, 1);

      // Reset mid-squeeze with two words outstanding, then a clean grant
      msg(1, SHA3_512, 3, 2, 0, 0, 0, 1, -1, 0);
      msg(2, SHAKE128, 2, 1, 0, 0, 0, -1, -1, 1);

      // Core stalls mid-squeeze: no last, no error, then resumes
      msg(0, SHAKE256, 3, 1, 0, 0, 0, -1, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
